// File: rtl/sub_div_top.sv
// sub_div_top: unsigned integer divider by repeated subtraction.
//
// The remainder, divisor and quotient working registers are loaded when start
// is seen in IDLE. The FSM then alternates CHECK/SUB until the remainder is
// smaller than the divisor. The results are copied to the output registers on
// the CHECK->DONE transition. Start is a level handshake: after DONE, start
// must drop before another operation can begin.
//
// Optional feature macro: DIV_ZERO_ERR_EN adds the div_err output.
//
// Ports:
//   clk        system clock, rising edge
//   resetn     asynchronous active-low reset
//   start      level request, sampled only in IDLE
//   ain, bin   dividend / divisor (unsigned), captured on the start edge
//   quotient   registered ain / bin (all-ones on divide-by-zero)
//   remainder  registered ain mod bin (dividend on divide-by-zero)
//   busy       high in CHECK or SUB
//   done       high while in DONE
//   div_err    (DIV_ZERO_ERR_EN only) last completion was a divide-by-zero
module sub_div_top #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [WIDTH-1:0] ain,
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done
`ifdef DIV_ZERO_ERR_EN
   ,
   output logic             div_err
`endif
);

   typedef enum logic [1:0] {IDLE, CHECK, SUB, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] div_r;
   logic [WIDTH-1:0] quo_r;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         rem_r     <= '0;
         div_r     <= '0;
         quo_r     <= '0;
         quotient  <= '0;
         remainder <= '0;
`ifdef DIV_ZERO_ERR_EN
         div_err   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  rem_r <= ain;
                  div_r <= bin;
                  quo_r <= '0;
                  state <= CHECK;
               end
            end
            CHECK: begin
               if (div_r == '0) begin
                  // Divide-by-zero still terminates and reports all-ones.
                  quotient  <= '1;
                  remainder <= rem_r;
`ifdef DIV_ZERO_ERR_EN
                  div_err   <= 1'b1;
`endif
                  state     <= DONE;
               end else if (rem_r >= div_r) begin
                  state <= SUB;
               end else begin
                  quotient  <= quo_r;
                  remainder <= rem_r;
`ifdef DIV_ZERO_ERR_EN
                  div_err   <= 1'b0;
`endif
                  state     <= DONE;
               end
            end
            SUB: begin
               // The subtraction cannot wrap because CHECK guarantees rem_r >= div_r.
               rem_r <= rem_r - div_r;
               quo_r <= quo_r + 1'b1;
               state <= CHECK;
            end
            DONE: begin
               // A held start level never retriggers an operation.
               if (!start) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Decoded from the state register only; there is no path from the inputs.
   assign busy = (state == CHECK) || (state == SUB);
   assign done = (state == DONE);

endmodule
